// File: rtl/ramen_order_arb_if.sv
// ramen_order_arb_if
// Kiosk-side bus of the ramen order arbiter. It bundles the four kiosks'
// request, order and response signals.
//   req          [3:0]  per-kiosk order request, held until that kiosk's gnt bit pulses
//   req_type     [7:0]  kiosk i ramen type at bits [2i+1:2i]
//   req_portion  [3:0]  kiosk i portion at bit i
//   gnt          [3:0]  one-hot one-cycle pulse marking the accepted kiosk
//   resp_valid   [3:0]  one-hot one-cycle pulse returning the result to the owner
//   resp_success        order result, meaningful only while resp_valid is non-zero
// Modports: master = kiosk side, slave = arbiter side.
interface ramen_order_arb_if;
    logic [3:0] req;
    logic [7:0] req_type;
    logic [3:0] req_portion;
    logic [3:0] gnt;
    logic [3:0] resp_valid;
    logic       resp_success;

    modport master (
        output req, req_type, req_portion,
        input  gnt, resp_valid, resp_success
    );

    modport slave (
        input  req, req_type, req_portion,
        output gnt, resp_valid, resp_success
    );
endinterface

// File: rtl/ramen_order_arb.sv
// ramen_order_arb
// Round-robin arbiter that lets four kiosks share one kitchen. A granted
// order is sent to the kitchen over two cycles (type, then portion), the
// kitchen's answer is returned to the owning kiosk, and a manager close
// request makes the next order also collect the session totals.
// A watchdog gives up on a silent kitchen after eight waiting cycles.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   kiosk                kiosk bus (ramen_order_arb_if.slave)
//   close_req            one-cycle manager pulse ending the selling session
//   close_done           one-cycle pulse when totals are captured
//   tot_sold, tot_gain   captured totals, held until the next close_done
//   err                  one-cycle watchdog timeout pulse
//   k_in_valid, k_ramen_type, k_portion, k_selling   to the kitchen
//   k_out_valid_order, k_success, k_out_valid_tot,
//   k_sold_num, k_total_gain                        from the kitchen
module ramen_order_arb (
    input  logic        clk,
    input  logic        rst_n,
    ramen_order_arb_if.slave kiosk,
    input  logic        close_req,
    output logic        close_done,
    output logic [27:0] tot_sold,
    output logic [14:0] tot_gain,
    output logic        err,
    output logic        k_in_valid,
    output logic [1:0]  k_ramen_type,
    output logic        k_portion,
    output logic        k_selling,
    input  logic        k_out_valid_order,
    input  logic        k_success,
    input  logic        k_out_valid_tot,
    input  logic [27:0] k_sold_num,
    input  logic [14:0] k_total_gain
);

    typedef enum logic [2:0] {IDLE, SEND1, SEND2, WAIT_ORD, WAIT_TOT} state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] rr_ptr;
    logic       close_pending;
    logic [3:0] wdog;
    logic [1:0] owner;
    logic [1:0] lat_type;
    logic       lat_portion;
    logic       lat_close;

    logic       grant_found;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       close_flag;
    logic       wdog_expired;

    // A close request arriving in the same cycle as a grant still belongs
    // to that order.
    assign close_flag   = close_pending | close_req;
    // wdog counts completed waiting cycles, so 7 marks the eighth one.
    assign wdog_expired = (wdog == 4'd7);

    // Round-robin search starting at rr_ptr. Arbitration only happens in
    // IDLE, when no kiosk owns the kitchen, so an owner's req is never seen.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!grant_found && kiosk.req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (grant_found) next_state = SEND1;
            SEND1:    next_state = SEND2;
            SEND2:    next_state = WAIT_ORD;
            WAIT_ORD: begin
                if (k_out_valid_order) begin
                    next_state = lat_close ? WAIT_TOT : IDLE;
                end else if (wdog_expired) begin
                    next_state = IDLE;
                end
            end
            WAIT_TOT: if (k_out_valid_tot || wdog_expired) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs. Every output is computed from the
    // current state, so it becomes visible one cycle after that state is
    // entered; pulses default to 0 and k_selling defaults to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr             <= 2'd0;
            close_pending      <= 1'b0;
            wdog               <= 4'd0;
            owner              <= 2'd0;
            lat_type           <= 2'd0;
            lat_portion        <= 1'b0;
            lat_close          <= 1'b0;
            kiosk.gnt          <= 4'd0;
            kiosk.resp_valid   <= 4'd0;
            kiosk.resp_success <= 1'b0;
            close_done         <= 1'b0;
            tot_sold           <= 28'd0;
            tot_gain           <= 15'd0;
            err                <= 1'b0;
            k_in_valid         <= 1'b0;
            k_ramen_type       <= 2'd0;
            k_portion          <= 1'b0;
            k_selling          <= 1'b1;
        end else begin
            kiosk.gnt          <= 4'd0;
            kiosk.resp_valid   <= 4'd0;
            kiosk.resp_success <= 1'b0;
            close_done         <= 1'b0;
            err                <= 1'b0;
            k_in_valid         <= 1'b0;
            k_ramen_type       <= 2'd0;
            k_portion          <= 1'b0;
            k_selling          <= 1'b1;

            // Set here; a completed close below overrides it in the same cycle.
            if (close_req) close_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (grant_found) begin
                        kiosk.gnt   <= 4'b0001 << grant_idx;
                        owner       <= grant_idx;
                        lat_type    <= kiosk.req_type[{grant_idx, 1'b0} +: 2];
                        lat_portion <= kiosk.req_portion[grant_idx];
                        lat_close   <= close_flag;
                        rr_ptr      <= grant_idx + 2'd1;
                    end
                end
                SEND1: begin
                    k_in_valid   <= 1'b1;
                    k_ramen_type <= lat_type;
                    k_selling    <= ~lat_close;
                end
                SEND2: begin
                    k_in_valid <= 1'b1;
                    k_portion  <= lat_portion;
                    k_selling  <= ~lat_close;
                    wdog       <= 4'd0;
                end
                WAIT_ORD: begin
                    k_selling <= ~lat_close;
                    if (k_out_valid_order) begin
                        kiosk.resp_valid   <= 4'b0001 << owner;
                        kiosk.resp_success <= k_success;
                        wdog               <= 4'd0;
                    end else if (wdog_expired) begin
                        // The owner gets a failed result; a pending close waits
                        // for the next order.
                        err              <= 1'b1;
                        kiosk.resp_valid <= 4'b0001 << owner;
                    end else begin
                        wdog <= wdog + 4'd1;
                    end
                end
                WAIT_TOT: begin
                    if (k_out_valid_tot) begin
                        tot_sold      <= k_sold_num;
                        tot_gain      <= k_total_gain;
                        close_done    <= 1'b1;
                        close_pending <= 1'b0;
                    end else if (wdog_expired) begin
                        tot_sold      <= 28'd0;
                        tot_gain      <= 15'd0;
                        close_done    <= 1'b1;
                        err           <= 1'b1;
                        close_pending <= 1'b0;
                    end else begin
                        wdog <= wdog + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ramen_order_arb.sv
// tb_ramen_order_arb
// Directed testbench for ramen_order_arb. Inputs are driven and outputs are
// sampled on the falling clock edge; expected values are hand-computed.
module tb_ramen_order_arb;

    logic        clk;
    logic        rst_n;
    logic        close_req;
    logic        close_done;
    logic [27:0] tot_sold;
    logic [14:0] tot_gain;
    logic        err;
    logic        k_in_valid;
    logic [1:0]  k_ramen_type;
    logic        k_portion;
    logic        k_selling;
    logic        k_out_valid_order;
    logic        k_success;
    logic        k_out_valid_tot;
    logic [27:0] k_sold_num;
    logic [14:0] k_total_gain;

    int check_count;
    int error_count;

    ramen_order_arb_if kiosk ();

    ramen_order_arb dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .kiosk             (kiosk),
        .close_req         (close_req),
        .close_done        (close_done),
        .tot_sold          (tot_sold),
        .tot_gain          (tot_gain),
        .err               (err),
        .k_in_valid        (k_in_valid),
        .k_ramen_type      (k_ramen_type),
        .k_portion         (k_portion),
        .k_selling         (k_selling),
        .k_out_valid_order (k_out_valid_order),
        .k_success         (k_success),
        .k_out_valid_tot   (k_out_valid_tot),
        .k_sold_num        (k_sold_num),
        .k_total_gain      (k_total_gain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hang anywhere in the directed sequence.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] t,
                                 input logic [3:0] p, input logic c);
        kiosk.req         = r;
        kiosk.req_type    = t;
        kiosk.req_portion = p;
        close_req         = c;
    endtask

    // Waits (bounded) for the next grant, drops the expected kiosk's request,
    // answers the kitchen at the first WAIT_ORD cycle and checks the response.
    task automatic runOrder(input logic [3:0] exp_gnt, input logic succ, input string tag);
        int n;
        n = 0;
        step();
        while (kiosk.gnt == 4'd0 && n < 20) begin
            step();
            n++;
        end
        checkOutput({tag, "_gnt"}, 32'(kiosk.gnt), 32'(exp_gnt));
        kiosk.req = kiosk.req & ~exp_gnt;
        step();
        step();
        k_out_valid_order = 1'b1;
        k_success         = succ;
        step();
        k_out_valid_order = 1'b0;
        k_success         = 1'b0;
        checkOutput({tag, "_resp_valid"}, 32'(kiosk.resp_valid), 32'(exp_gnt));
        checkOutput({tag, "_resp_success"}, 32'(kiosk.resp_success), 32'(succ));
    endtask

    initial begin
        check_count       = 0;
        error_count       = 0;
        rst_n             = 1'b0;
        k_out_valid_order = 1'b0;
        k_success         = 1'b0;
        k_out_valid_tot   = 1'b0;
        k_sold_num        = 28'd0;
        k_total_gain      = 15'd0;
        applyStimulus(4'd0, 8'd0, 4'd0, 1'b0);

        // Reset values
        step();
        step();
        checkOutput("rst_gnt", 32'(kiosk.gnt), 32'd0);
        checkOutput("rst_k_selling", 32'(k_selling), 32'd1);
        checkOutput("rst_k_in_valid", 32'(k_in_valid), 32'd0);
        checkOutput("rst_resp_valid", 32'(kiosk.resp_valid), 32'd0);
        checkOutput("rst_close_done", 32'(close_done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step();

        // Fairness: all four request, each served kiosk re-raises
        applyStimulus(4'b1111, 8'd0, 4'd0, 1'b0);
        runOrder(4'b0001, 1'b1, "fair0");
        kiosk.req = kiosk.req | 4'b0001;
        runOrder(4'b0010, 1'b0, "fair1");
        kiosk.req = kiosk.req | 4'b0010;
        runOrder(4'b0100, 1'b1, "fair2");
        kiosk.req = kiosk.req | 4'b0100;
        runOrder(4'b1000, 1'b1, "fair3");
        kiosk.req = kiosk.req | 4'b1000;
        runOrder(4'b0001, 1'b1, "fair_wrap");
        kiosk.req = 4'd0;
        step();

        // Single order, kiosk 0, type 2, portion 1, kitchen answers 4 cycles
        // after the first k_in_valid
        applyStimulus(4'b0001, 8'b0000_0010, 4'b0001, 1'b0);
        step();
        checkOutput("single_gnt", 32'(kiosk.gnt), 32'b0001);
        kiosk.req = 4'd0;
        step();
        checkOutput("single_send1_valid", 32'(k_in_valid), 32'd1);
        checkOutput("single_send1_type", 32'(k_ramen_type), 32'd2);
        checkOutput("single_send1_portion", 32'(k_portion), 32'd0);
        checkOutput("single_send1_selling", 32'(k_selling), 32'd1);
        step();
        checkOutput("single_send2_valid", 32'(k_in_valid), 32'd1);
        checkOutput("single_send2_type", 32'(k_ramen_type), 32'd0);
        checkOutput("single_send2_portion", 32'(k_portion), 32'd1);
        step();
        checkOutput("single_valid_drop", 32'(k_in_valid), 32'd0);
        step();
        step();
        k_out_valid_order = 1'b1;
        k_success         = 1'b1;
        checkOutput("single_resp_early", 32'(kiosk.resp_valid), 32'd0);
        step();
        k_out_valid_order = 1'b0;
        k_success         = 1'b0;
        checkOutput("single_resp_valid", 32'(kiosk.resp_valid), 32'b0001);
        checkOutput("single_resp_success", 32'(kiosk.resp_success), 32'd1);
        step();
        checkOutput("single_resp_pulse", 32'(kiosk.resp_valid), 32'd0);
        checkOutput("single_resp_success_idle", 32'(kiosk.resp_success), 32'd0);

        // Stray kitchen strobe while idle is ignored
        k_out_valid_order = 1'b1;
        k_success         = 1'b1;
        step();
        k_out_valid_order = 1'b0;
        k_success         = 1'b0;
        checkOutput("stray_resp_valid", 32'(kiosk.resp_valid), 32'd0);
        checkOutput("stray_gnt", 32'(kiosk.gnt), 32'd0);

        // Close pending without requests generates no kitchen traffic
        applyStimulus(4'd0, 8'd0, 4'd0, 1'b1);
        step();
        close_req = 1'b0;
        step();
        step();
        checkOutput("close_idle_gnt", 32'(kiosk.gnt), 32'd0);
        checkOutput("close_idle_k_in_valid", 32'(k_in_valid), 32'd0);
        close_req = 1'b1;
        step();
        close_req = 1'b0;

        // Close order from kiosk 2, type 3, portion 0
        applyStimulus(4'b0100, 8'b0011_0000, 4'b0000, 1'b0);
        step();
        checkOutput("close_gnt", 32'(kiosk.gnt), 32'b0100);
        kiosk.req = 4'd0;
        step();
        checkOutput("close_send1_selling", 32'(k_selling), 32'd0);
        checkOutput("close_send1_type", 32'(k_ramen_type), 32'd3);
        step();
        checkOutput("close_send2_selling", 32'(k_selling), 32'd0);
        checkOutput("close_send2_portion", 32'(k_portion), 32'd0);
        step();
        checkOutput("close_wait_selling", 32'(k_selling), 32'd0);
        k_out_valid_order = 1'b1;
        k_success         = 1'b1;
        step();
        k_out_valid_order = 1'b0;
        k_success         = 1'b0;
        checkOutput("close_resp_valid", 32'(kiosk.resp_valid), 32'b0100);
        checkOutput("close_resp_success", 32'(kiosk.resp_success), 32'd1);
        checkOutput("close_done_early", 32'(close_done), 32'd0);
        k_out_valid_tot = 1'b1;
        k_sold_num      = 28'h0204081;
        k_total_gain    = 15'd1100;
        step();
        k_out_valid_tot = 1'b0;
        k_sold_num      = 28'd0;
        k_total_gain    = 15'd0;
        checkOutput("close_done", 32'(close_done), 32'd1);
        checkOutput("close_tot_sold", 32'(tot_sold), 32'h0204081);
        checkOutput("close_tot_gain", 32'(tot_gain), 32'd1100);
        checkOutput("close_err", 32'(err), 32'd0);
        step();
        checkOutput("close_done_pulse", 32'(close_done), 32'd0);
        checkOutput("close_tot_sold_held", 32'(tot_sold), 32'h0204081);
        checkOutput("close_selling_back", 32'(k_selling), 32'd1);

        // Same-cycle close with grant, then totals never arrive
        applyStimulus(4'b0010, 8'b0000_0100, 4'b0010, 1'b1);
        step();
        checkOutput("samecyc_gnt", 32'(kiosk.gnt), 32'b0010);
        applyStimulus(4'd0, 8'd0, 4'd0, 1'b0);
        step();
        checkOutput("samecyc_selling", 32'(k_selling), 32'd0);
        step();
        k_out_valid_order = 1'b1;
        step();
        k_out_valid_order = 1'b0;
        checkOutput("samecyc_resp_valid", 32'(kiosk.resp_valid), 32'b0010);
        checkOutput("samecyc_resp_success", 32'(kiosk.resp_success), 32'd0);
        for (int i = 0; i < 7; i++) step();
        checkOutput("tot_timeout_err_early", 32'(err), 32'd0);
        checkOutput("tot_timeout_done_early", 32'(close_done), 32'd0);
        step();
        checkOutput("tot_timeout_err", 32'(err), 32'd1);
        checkOutput("tot_timeout_done", 32'(close_done), 32'd1);
        checkOutput("tot_timeout_sold", 32'(tot_sold), 32'd0);
        checkOutput("tot_timeout_gain", 32'(tot_gain), 32'd0);

        // Order timeout: kitchen never answers, kiosk 3
        step();
        applyStimulus(4'b1000, 8'b0100_0000, 4'b1000, 1'b0);
        step();
        checkOutput("ord_timeout_gnt", 32'(kiosk.gnt), 32'b1000);
        kiosk.req = 4'd0;
        step();
        checkOutput("ord_timeout_selling", 32'(k_selling), 32'd1);
        for (int i = 0; i < 8; i++) step();
        checkOutput("ord_timeout_err_early", 32'(err), 32'd0);
        step();
        checkOutput("ord_timeout_err", 32'(err), 32'd1);
        checkOutput("ord_timeout_resp_valid", 32'(kiosk.resp_valid), 32'b1000);
        checkOutput("ord_timeout_resp_success", 32'(kiosk.resp_success), 32'd0);
        step();
        checkOutput("ord_timeout_err_pulse", 32'(err), 32'd0);

        // Reset while waiting for the kitchen, with rr_ptr moved to 2
        applyStimulus(4'b0010, 8'd0, 4'b0010, 1'b0);
        step();
        checkOutput("midrst_gnt", 32'(kiosk.gnt), 32'b0010);
        kiosk.req = 4'd0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_k_in_valid", 32'(k_in_valid), 32'd0);
        checkOutput("midrst_k_selling", 32'(k_selling), 32'd1);
        checkOutput("midrst_k_portion", 32'(k_portion), 32'd0);
        step();
        rst_n             = 1'b1;
        k_out_valid_order = 1'b1;
        k_success         = 1'b1;
        step();
        k_out_valid_order = 1'b0;
        k_success         = 1'b0;
        checkOutput("midrst_no_resp", 32'(kiosk.resp_valid), 32'd0);
        applyStimulus(4'b1010, 8'd0, 4'd0, 1'b0);
        runOrder(4'b0010, 1'b1, "postrst_first");
        runOrder(4'b1000, 1'b0, "postrst_next");
        kiosk.req = 4'd0;
        step();

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
